periph_bridge: RTL and testbench
================================

PERIPH_BRIDGE -- requirements
Module: periph_bridge

Interface
REQ-001 SHALL have parameter N_DEV, default 2: number of attached devices, 1..8.
REQ-002 SHALL have parameter DATA_W, default 32: data width, multiple of 8.
REQ-003 SHALL have parameter DEV_BASE, default {32'h7F10, 32'h7F00}: N_DEV x 32-bit base addresses, device k in slice k.
REQ-004 SHALL have parameter DEV_LIMIT, default {32'h7F1B, 32'h7F0B}: N_DEV x 32-bit inclusive upper addresses.
REQ-005 SHALL have parameter TIMEOUT, default 16: maximum wait cycles before error, 1..255.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 pr_req  in  1  CPU access request, sampled in IDLE only.
REQ-009 pr_addr  in  32  CPU byte address.
REQ-010 pr_we  in  1  write (1) / read (0).
REQ-011 pr_be  in  DATA_W/8  byte enables.
REQ-012 pr_wd  in  DATA_W  write data.
REQ-013 pr_rd  out  DATA_W  registered read data.
REQ-014 pr_ack  out  1  one-cycle completion pulse.
REQ-015 pr_err  out  1  error qualifier, valid with pr_ack.
REQ-016 dev_addr  out  30  latched word address pr_addr[31:2].
REQ-017 dev_wd, dev_be  out  DATA_W, DATA_W/8  latched write data, byte enables.
REQ-018 dev_sel, dev_we  out  N_DEV each  one-hot select, write strobe.
REQ-019 dev_rd  in  N_DEV*DATA_W  packed device read data.
REQ-020 dev_rdy  in  N_DEV  device completion.
REQ-021 dev_irq  in  N_DEV  level interrupt requests, asynchronous to access.
REQ-022 hw_int  out  N_DEV  synchronised interrupt vector.

Function
REQ-023 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-024 IDLE + pr_req SHALL decode: hit k iff DEV_BASE[k] <= pr_addr <= DEV_LIMIT[k]; overlapping windows resolve to lowest k.
REQ-025 No hit, pr_addr[1:0] != 0, or pr_be == 0 SHALL go to RESP with err set, no device touched.
REQ-026 Hit SHALL latch addr/wd/be/we/k and go to ACCESS; wait counter cleared.
REQ-027 In ACCESS, dev_sel[k]=1 and dev_we[k]=latched we; all other bits 0; 0 in IDLE/RESP.
REQ-028 ACCESS + dev_rdy[k] SHALL capture dev_rd slice k into pr_rd (reads only; writes keep pr_rd) and go to RESP, err=0.
REQ-029 ACCESS without rdy SHALL increment counter; reaching TIMEOUT SHALL go to RESP with err=1, pr_rd unchanged.
REQ-030 RESP SHALL assert pr_ack for exactly one cycle, then IDLE; pr_err valid only while pr_ack=1.
REQ-031 Minimum latency: req at cycle n, rdy at n+1 -> pr_ack at n+2; error path pr_ack at n+1.
REQ-032 pr_req outside IDLE SHALL be ignored; requester SHALL hold request until pr_ack; back-to-back req accepted in cycle after ack.
REQ-033 dev_rdy of unselected devices SHALL be ignored.
REQ-034 hw_int SHALL be dev_irq via two-flop synchroniser per bit: latency 2 cycles, independent of FSM.

Reset
REQ-035 reset_n low SHALL force IDLE, counter 0, pr_rd=0, pr_ack=0, pr_err=0, dev_sel=0, dev_we=0, latched addr/wd/be=0, hw_int=0, immediately, mid-access included; aborted access yields no ack.

Structure
REQ-036 State encoding, address-window width (32) and TIMEOUT counter width (8) SHALL live in the shared settings package.
REQ-037 One sub-module periph_decoder SHALL implement combinational address-to-one-hot decode with miss flag.

Verification
REQ-038 Read dev1, addr 0x7F10, rdy at +1 with data 0xDEADBEEF -> ack at cycle 2, pr_rd=0xDEADBEEF, err=0.
REQ-039 Write dev0 0x7F04, be=4'b0011, rdy after 3 waits -> dev_we[0] high 4 cycles, dev_wd/dev_be stable, ack at cycle 5.
REQ-040 Access 0x7F20 (unmapped) and 0x7F02 (misaligned) -> ack+err at cycle 1, dev_sel stays 0.
REQ-041 Dev0 never rdy, TIMEOUT=16 -> ack+err after 16 ACCESS cycles, pr_rd unchanged.
REQ-042 reset_n low mid-ACCESS -> all outputs 0 same cycle, no ack; release then new read completes normally.
REQ-043 dev_irq[1] pulse 3 cycles -> hw_int[1] high 3 cycles starting 2 cycles later, unaffected by concurrent accesses.

Source files
------------

// File: rtl/periph_bridge_pkg.sv
// Shared settings for the peripheral bridge: FSM encoding and fixed widths.
package periph_bridge_pkg;

    // Address comparison width for device windows.
    localparam int unsigned ADDR_W = 32;

    // Width of the access wait counter; bounds the usable TIMEOUT range.
    localparam int unsigned CNT_W = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

endpackage

// File: rtl/periph_bridge_if.sv
// CPU-side and device-side signal bundle of the peripheral bridge.
interface periph_bridge_if
    import periph_bridge_pkg::*;
#(
    parameter int unsigned N_DEV  = 2,
    parameter int unsigned DATA_W = 32
);

    // CPU side
    logic                  pr_req;
    logic [ADDR_W-1:0]     pr_addr;
    logic                  pr_we;
    logic [DATA_W/8-1:0]   pr_be;
    logic [DATA_W-1:0]     pr_wd;
    logic [DATA_W-1:0]     pr_rd;
    logic                  pr_ack;
    logic                  pr_err;

    // Device side
    logic [ADDR_W-3:0]     dev_addr;
    logic [DATA_W-1:0]     dev_wd;
    logic [DATA_W/8-1:0]   dev_be;
    logic [N_DEV-1:0]      dev_sel;
    logic [N_DEV-1:0]      dev_we;
    logic [N_DEV*DATA_W-1:0] dev_rd;
    logic [N_DEV-1:0]      dev_rdy;
    logic [N_DEV-1:0]      dev_irq;
    logic [N_DEV-1:0]      hw_int;

    // The bridge itself
    modport slave (
        input  pr_req, pr_addr, pr_we, pr_be, pr_wd,
        output pr_rd, pr_ack, pr_err,
        output dev_addr, dev_wd, dev_be, dev_sel, dev_we,
        input  dev_rd, dev_rdy, dev_irq,
        output hw_int
    );

    // The surrounding CPU and devices
    modport master (
        output pr_req, pr_addr, pr_we, pr_be, pr_wd,
        input  pr_rd, pr_ack, pr_err,
        input  dev_addr, dev_wd, dev_be, dev_sel, dev_we,
        output dev_rd, dev_rdy, dev_irq,
        input  hw_int
    );

endinterface

// File: rtl/periph_decoder.sv
// Combinational address decode: one-hot device select plus miss flag.
// Overlapping windows resolve to the lowest device index.
module periph_decoder
    import periph_bridge_pkg::*;
#(
    parameter int unsigned             N_DEV     = 2,
    parameter logic [N_DEV*ADDR_W-1:0] DEV_BASE  = {32'h7F10, 32'h7F00},
    parameter logic [N_DEV*ADDR_W-1:0] DEV_LIMIT = {32'h7F1B, 32'h7F0B}
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [N_DEV-1:0]  sel_o,
    output logic              miss_o
);

    // First matching window wins; later matches are suppressed.
    always_comb begin
        logic found;
        found  = 1'b0;
        sel_o  = '0;
        for (int unsigned k = 0; k < N_DEV; k++) begin
            if (!found && addr_i >= DEV_BASE[k*ADDR_W +: ADDR_W]
                       && addr_i <= DEV_LIMIT[k*ADDR_W +: ADDR_W]) begin
                sel_o[k] = 1'b1;
                found    = 1'b1;
            end
        end
        miss_o = !found;
    end

endmodule

// File: rtl/periph_bridge.sv
// Single-outstanding CPU-to-peripheral bridge with address decode, wait
// timeout and a two-flop interrupt synchroniser.
module periph_bridge
    import periph_bridge_pkg::*;
#(
    parameter int unsigned             N_DEV     = 2,
    parameter int unsigned             DATA_W    = 32,
    parameter logic [N_DEV*ADDR_W-1:0] DEV_BASE  = {32'h7F10, 32'h7F00},
    parameter logic [N_DEV*ADDR_W-1:0] DEV_LIMIT = {32'h7F1B, 32'h7F0B},
    parameter int unsigned             TIMEOUT   = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    periph_bridge_if.slave  bus
);

    localparam int unsigned BE_W = DATA_W / 8;

    state_e              state_q, state_d;
    cnt_t                cnt_q, cnt_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [ADDR_W-3:0]   addr_q, addr_d;
    logic [N_DEV-1:0]    sel_q, sel_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [N_DEV-1:0]    irq_meta_q, irq_sync_q;

    logic [N_DEV-1:0]    dec_sel;
    logic                dec_miss;
    logic [DATA_W-1:0]   rd_mux;
    logic                sel_rdy;

    periph_decoder #(
        .N_DEV     (N_DEV),
        .DEV_BASE  (DEV_BASE),
        .DEV_LIMIT (DEV_LIMIT)
    ) u_decoder (
        .addr_i (bus.pr_addr),
        .sel_o  (dec_sel),
        .miss_o (dec_miss)
    );

    // Pick the selected device's read data and ready; others are ignored.
    always_comb begin
        rd_mux  = '0;
        sel_rdy = |(bus.dev_rdy & sel_q);
        for (int unsigned k = 0; k < N_DEV; k++) begin
            if (sel_q[k]) begin
                rd_mux = rd_mux | bus.dev_rd[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and transaction bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wd_d    = wd_q;
        be_d    = be_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (bus.pr_req) begin
                    if (dec_miss || (bus.pr_addr[1:0] != 2'b00) || (bus.pr_be == '0)) begin
                        // Rejected without touching any device.
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        addr_d  = bus.pr_addr[ADDR_W-1:2];
                        wd_d    = bus.pr_wd;
                        be_d    = bus.pr_be;
                        we_d    = bus.pr_we;
                        sel_d   = dec_sel;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (sel_rdy) begin
                    if (!we_q) begin
                        rd_d = rd_mux;
                    end
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == cnt_t'(TIMEOUT - 1)) begin
                    // This was the last permitted wait cycle.
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and latched transaction state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rd_q    <= '0;
            wd_q    <= '0;
            be_q    <= '0;
            addr_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wd_q    <= wd_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    // Interrupt synchroniser, free-running and independent of the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_meta_q <= '0;
            irq_sync_q <= '0;
        end else begin
            irq_meta_q <= bus.dev_irq;
            irq_sync_q <= irq_meta_q;
        end
    end

    // Output decode from registered state.
    always_comb begin
        bus.pr_rd    = rd_q;
        bus.pr_ack   = (state_q == StResp);
        bus.pr_err   = (state_q == StResp) && err_q;
        bus.dev_addr = addr_q;
        bus.dev_wd   = wd_q;
        bus.dev_be   = be_q;
        bus.dev_sel  = (state_q == StAccess) ? sel_q : '0;
        bus.dev_we   = (state_q == StAccess) ? (sel_q & {N_DEV{we_q}}) : '0;
        bus.hw_int   = irq_sync_q;
    end

endmodule

// File: tb/tb_periph_bridge.sv
// Randomised bench for periph_bridge against a transaction-level model.
module tb_periph_bridge;

    localparam int unsigned N_DEV   = 2;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    logic clk;
    logic reset_n;

    int n_tests;
    int n_fail;

    logic [31:0] win_base  [N_DEV];
    logic [31:0] win_limit [N_DEV];
    logic [31:0] rd_model;
    bit          run_irq;

    periph_bridge_if #(.N_DEV(N_DEV), .DATA_W(DATA_W)) bus ();

    periph_bridge #(
        .N_DEV     (N_DEV),
        .DATA_W    (DATA_W),
        .DEV_BASE  ({32'h7F10, 32'h7F00}),
        .DEV_LIMIT ({32'h7F1B, 32'h7F0B}),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete CPU access, starting at a negedge with the bridge idle.
    // The target device answers after 'waits' wait cycles with 'data'.
    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wd, input int waits, input logic [31:0] data);
        int   k;
        bit   bad;
        bit   tmo;
        int   lat;
        logic [1:0] exp_sel;
        k = -1;
        for (int i = 0; i < N_DEV; i++) begin
            if (k < 0 && addr >= win_base[i] && addr <= win_limit[i]) k = i;
        end
        bad = (k < 0) || (addr[1:0] != 2'b00) || (be == 4'h0);
        tmo = !bad && (waits >= TIMEOUT);
        if (bad)      lat = 1;
        else if (tmo) lat = TIMEOUT + 1;
        else          lat = waits + 2;
        exp_sel = bad ? 2'b00 : 2'(1 << k);

        bus.pr_req  = 1'b1;
        bus.pr_addr = addr;
        bus.pr_we   = we;
        bus.pr_be   = be;
        bus.pr_wd   = wd;
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) begin
                next_cycle();
                check_eq("ack", bus.pr_ack, c == lat);
                check_eq("err", bus.pr_err, (c == lat) && (bad || tmo));
                if (c < lat) begin
                    check_eq("dev_sel", bus.dev_sel, exp_sel);
                    check_eq("dev_we", bus.dev_we, we ? exp_sel : 2'b00);
                    if (!bad) begin
                        check_eq("dev_addr", bus.dev_addr, addr[31:2]);
                        check_eq("dev_wd", bus.dev_wd, wd);
                        check_eq("dev_be", bus.dev_be, be);
                    end
                end else begin
                    check_eq("dev_sel_idle", bus.dev_sel, 2'b00);
                    check_eq("dev_we_idle", bus.dev_we, 2'b00);
                    if (!bad && !tmo && !we) rd_model = data;
                    check_eq("pr_rd", bus.pr_rd, rd_model);
                end
            end
            // Inputs for the second half of cycle c; unselected devices babble.
            bus.dev_rd  = {$urandom, $urandom};
            bus.dev_rdy = 2'($urandom);
            if (k >= 0) begin
                bus.dev_rdy[k] = !bad && (c == waits + 1);
                if (c == waits + 1) bus.dev_rd[k*DATA_W +: DATA_W] = data;
            end
            if (c == lat) bus.pr_req = 1'b0;
        end
        bus.dev_rdy = '0;
        next_cycle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        win_base[0]  = 32'h7F00;
        win_limit[0] = 32'h7F0B;
        win_base[1]  = 32'h7F10;
        win_limit[1] = 32'h7F1B;
        rd_model = '0;
        run_irq  = 1'b1;

        bus.pr_req  = 1'b0;
        bus.pr_addr = '0;
        bus.pr_we   = 1'b0;
        bus.pr_be   = '0;
        bus.pr_wd   = '0;
        bus.dev_rd  = '0;
        bus.dev_rdy = '0;
        bus.dev_irq = '0;
        reset_n     = 1'b0;
        #1;
        check_eq("rst_ack", bus.pr_ack, 1'b0);
        check_eq("rst_err", bus.pr_err, 1'b0);
        check_eq("rst_rd", bus.pr_rd, 32'h0);
        check_eq("rst_sel", bus.dev_sel, 2'b00);
        check_eq("rst_we", bus.dev_we, 2'b00);
        check_eq("rst_addr", bus.dev_addr, 30'h0);
        check_eq("rst_hw_int", bus.hw_int, 2'b00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        next_cycle();

        // Directed corner cases.
        do_txn(32'h7F10, 1'b0, 4'hF, 32'h0, 0, 32'hDEADBEEF);
        do_txn(32'h7F04, 1'b1, 4'b0011, 32'hA5A5_1234, 3, 32'h0);
        do_txn(32'h7F20, 1'b0, 4'hF, 32'h0, 0, 32'h1111_1111);
        do_txn(32'h7F02, 1'b0, 4'hF, 32'h0, 0, 32'h2222_2222);
        do_txn(32'h7F08, 1'b0, 4'h0, 32'h0, 0, 32'h3333_3333);
        do_txn(32'h7F00, 1'b0, 4'hF, 32'h0, 40, 32'h4444_4444);
        do_txn(32'h7F1B & ~32'h3, 1'b0, 4'hF, 32'h0, 15, 32'h5555_5555);
        do_txn(32'h7F0C, 1'b0, 4'hF, 32'h0, 0, 32'h6666_6666);

        // Reset in the middle of an access.
        bus.dev_irq = 2'b11;
        bus.pr_req  = 1'b1;
        bus.pr_addr = 32'h7F08;
        bus.pr_we   = 1'b1;
        bus.pr_be   = 4'hF;
        bus.pr_wd   = 32'hCAFE_F00D;
        repeat (3) next_cycle();
        check_eq("mid_sel", bus.dev_sel, 2'b01);
        check_eq("mid_hw_int", bus.hw_int, 2'b11);
        reset_n = 1'b0;
        bus.pr_req = 1'b0;
        #1;
        check_eq("arst_sel", bus.dev_sel, 2'b00);
        check_eq("arst_we", bus.dev_we, 2'b00);
        check_eq("arst_ack", bus.pr_ack, 1'b0);
        check_eq("arst_rd", bus.pr_rd, 32'h0);
        check_eq("arst_wd", bus.dev_wd, 32'h0);
        check_eq("arst_be", bus.dev_be, 4'h0);
        check_eq("arst_addr", bus.dev_addr, 30'h0);
        check_eq("arst_hw_int", bus.hw_int, 2'b00);
        rd_model = '0;
        bus.dev_irq = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check_eq("post_rst_ack", bus.pr_ack, 1'b0);
        end
        do_txn(32'h7F14, 1'b0, 4'hF, 32'h0, 1, 32'h0BAD_CAFE);

        // Random traffic with interrupts toggling alongside.
        fork
            begin
                for (int n = 0; n < 250; n++) begin
                    logic [31:0] a;
                    int w;
                    a = $urandom_range(32'h7F24, 32'h7EF8);
                    if ($urandom_range(4, 0) != 0) a[1:0] = 2'b00;
                    if ($urandom_range(9, 0) == 0) w = $urandom_range(20, 16);
                    else                           w = $urandom_range(5, 0);
                    do_txn(a, 1'($urandom), 4'($urandom), $urandom, w, $urandom);
                end
                run_irq = 1'b0;
            end
            begin
                logic [1:0] hist[$];
                logic [1:0] v;
                hist.push_back(2'b00);
                hist.push_back(2'b00);
                v = 2'b00;
                while (run_irq) begin
                    check_eq("hw_int", bus.hw_int, hist[hist.size()-2]);
                    if ($urandom_range(3, 0) == 0) v[$urandom_range(1, 0)] ^= 1'b1;
                    bus.dev_irq = v;
                    hist.push_back(v);
                    if (hist.size() > 4) void'(hist.pop_front());
                    @(negedge clk);
                end
            end
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
